// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM controller between the 6502 bus
// (port A) and a second master such as DMA or video fetch (port B).
// Accesses are serialised through IDLE -> ACCESS -> DONE. The transaction is
// held stable on the controller side until sram_ready arrives or the watchdog
// expires. Completion is reported to the winning port as a one-cycle ack,
// with err also set when the watchdog aborted the access.
//
// Build option: define SRAM_ARB_RR_EN for round-robin tie breaking.
// Without it, ties use fixed priority and A always wins.
//
// Handshake: a requester raises req with we/addr/wdata stable and keeps req
// high until it sees its one-cycle ack. The arbiter does not look at req
// while an ack is on the wire. A requester that drops req on seeing ack
// therefore never gets a duplicate access, and one that keeps req high gets
// a fresh access afterwards. On the controller side, a strobe
// (sram_read/sram_write) stays high with a constant address and data until a
// one-cycle sram_ready pulse. sram_ready outside ACCESS is ignored.
module sram_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_data_write,
  output logic              sram_read,
  output logic              sram_write,
  input  logic              sram_ready,
  input  logic [DATA_W-1:0] sram_data_read,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Watchdog width covers 0..TIMEOUT; at least one bit when disabled.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant;      // 0 = A, 1 = B; also the last port granted
  logic              we_q;
  logic              err_q;
  logic [WD_W-1:0]   wd;

  logic              pick_b;
  logic              take;
  logic              timeout_hit;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign state_dbg = state;

  // Winner selection for a new access.
  always_comb begin
    pick_b = 1'b0;
`ifdef SRAM_ARB_RR_EN
    pick_b = b_req && (!a_req || !grant);
`else
    pick_b = b_req && !a_req;
`endif
  end

  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  // Requests are not looked at while an ack is being presented.
  assign take        = (state == ST_IDLE) && (a_req || b_req) && !(a_ack || b_ack);
  assign timeout_hit = (TIMEOUT != 0) && (wd == WD_MAX);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take) state_nxt = ST_ACCESS;
      ST_ACCESS: if (sram_ready || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Transaction registers, strobes, watchdog and port responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant           <= 1'b0;
      we_q            <= 1'b0;
      err_q           <= 1'b0;
      wd              <= '0;
      sram_address    <= '0;
      sram_data_write <= '0;
      sram_read       <= 1'b0;
      sram_write      <= 1'b0;
      a_ack           <= 1'b0;
      b_ack           <= 1'b0;
      a_err           <= 1'b0;
      b_err           <= 1'b0;
      a_rdata         <= '0;
      b_rdata         <= '0;
      busy            <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_err <= 1'b0;
      b_err <= 1'b0;
      busy  <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (take) begin
            grant           <= pick_b;
            we_q            <= sel_we;
            sram_address    <= sel_addr;
            sram_data_write <= sel_wdata;
            sram_read       <= !sel_we;
            sram_write      <= sel_we;
            err_q           <= 1'b0;
            wd              <= '0;
          end
        end
        ST_ACCESS: begin
          if (sram_ready) begin
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            if (!we_q) begin
              if (grant) b_rdata <= sram_data_read;
              else       a_rdata <= sram_data_read;
            end
          end else if (timeout_hit) begin
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_DONE: begin
          if (grant) begin
            b_ack <= 1'b1;
            b_err <= err_q;
          end else begin
            a_ack <= 1'b1;
            a_err <= err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single external SRAM controller (`sram`) between the 6502 bus (port A) and a second bus master such as DMA or video fetch (port B). It sits between the requesters and the `sram` block's `address`/`data_write`/`read`/`write`/`ready`/`data_read` interface, on the SRAM clock domain. It serialises accesses, holds each transaction stable until the controller completes it, and returns read data and a completion pulse to the winning port. A watchdog aborts accesses the controller never completes.

## Interface

Parameters:
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 16, SRAM data width
- `TIMEOUT`, 255, cycles in ACCESS before abort; 0 disables the watchdog

Ports:
- `clk`  in  1  SRAM/arbiter clock; one clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `a_req`, `b_req`  in  1  request; held high until the matching ack
- `a_we`, `b_we`  in  1  1 = write, 0 = read; stable while req is high
- `a_addr`, `b_addr`  in  ADDR_W  word address
- `a_wdata`, `b_wdata`  in  DATA_W  write data
- `a_ack`, `b_ack`  out  1  one-cycle completion pulse
- `a_err`, `b_err`  out  1  high with ack when the access timed out
- `a_rdata`, `b_rdata`  out  DATA_W  registered read data; held until the next read ack on that port
- `sram_address`  out  ADDR_W  to controller
- `sram_data_write`  out  DATA_W  to controller
- `sram_read`, `sram_write`  out  1  active-high access strobes
- `sram_ready`  in  1  one-cycle completion pulse from controller; `sram_data_read` valid in the same cycle
- `sram_data_read`  in  DATA_W  read data
- `busy`  out  1  high in ACCESS and DONE

## Operation

- States: IDLE, ACCESS, DONE.
- IDLE: sample `a_req`/`b_req`.
  - Neither high: stay in IDLE.
  - One or both high: pick a winner, register its addr/wdata/we into `sram_*`, assert `sram_read` or `sram_write`, store the `grant` bit, and go to ACCESS.
- Arbitration, default build: fixed priority, A wins ties.
- ACCESS: strobe, address and write data stay constant.
  - On `sram_ready`: drop the strobe, capture `sram_data_read` into the granted port's rdata (reads only), and go to DONE.
  - Watchdog counter (width `$clog2(TIMEOUT+1)`, min 1) counts from 0 each cycle in ACCESS. When it reaches TIMEOUT with no `sram_ready`: drop the strobe, set the err flag, leave rdata unchanged, and go to DONE.
- DONE: pulse the granted port's ack (plus err if set) for exactly one cycle, then go to IDLE.
- Strobes are never high in DONE or IDLE. This guarantees at least two strobe-low cycles between accesses.
- A requester whose req is still high in the IDLE after its ack is treated as a new request.
- A req that rises during another port's access waits. No requests are dropped.
- `sram_ready` outside ACCESS is ignored.

## Timing

- All outputs are registered.
- Reset values: `sram_read`=0, `sram_write`=0, `sram_address`=0, `sram_data_write`=0, `a_ack`=`b_ack`=0, `a_err`=`b_err`=0, `a_rdata`=`b_rdata`=0, `busy`=0, state IDLE, grant=A, watchdog=0.
- Sequence:
  - Req sampled high at edge N: strobe high from edge N.
  - `sram_ready` high at edge M: strobe low and rdata valid from edge M.
  - Ack high from edge M+1 to M+2.
- Minimum request-to-ack time is 3 cycles (ready the cycle after the strobe).
- Timeout: ack+err at cycle TIMEOUT+2 after the strobe rose.
- Reset asserted mid-access: immediately clears all outputs, including an in-flight strobe. The aborted transaction gets no ack.

## Configuration

- `SRAM_ARB_RR_EN` defined: round-robin. On simultaneous requests, the port not granted most recently wins. After reset, A counts as last granted, so B wins the first tie.
- `SRAM_ARB_RR_EN` undefined: fixed priority, A always wins ties. B can starve under continuous A traffic.

## Test plan

- Single read: B reads 0x00123 while the controller returns 0xBEEF with ready 2 cycles after the strobe -> one `b_ack`, `b_rdata`=0xBEEF, `a_ack` stays 0, `sram_read` high exactly 2 cycles.
- Tie: A writes 0x0001 at 0x00010 and B reads 0x00020, both raised at the same edge -> default build: A acked first, B strobe starts 2 cycles after `a_ack`. With `SRAM_ARB_RR_EN`: B first, then A.
- Back-to-back: A holds req across 4 reads with ready 1 cycle after the strobe -> 4 acks spaced 4 cycles apart, strobe low ≥2 cycles between accesses.
- Timeout with TIMEOUT=8 and ready never asserted -> `sram_read` high 9 cycles, then `a_ack`=`a_err`=1 for 1 cycle, `a_rdata` unchanged, next request serviced normally.
- Reset mid-access: assert `reset_n`=0 while `sram_write` is high -> all outputs 0 immediately, no ack after release, new request completes normally.
- Stray ready: pulse `sram_ready` in IDLE -> no state change, no ack.
